// File: rtl/huffman_pack_ctrl.sv
// Sequencer and MSB-first bit packer around a static-table Huffman encoder.
// Optional HUFF_BITCOUNT_EN adds a saturating per-message code-bit counter port.
module huffman_pack_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             enc_enable,
  output logic [7:0]       enc_data,
  input  logic [7:0]       enc_code,
  input  logic [LEN_W-1:0] enc_len,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             err_sym
`ifdef HUFF_BITCOUNT_EN
  ,
  output logic [15:0]      bit_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, CAP, EMIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        s_ready_q, s_ready_d;
  logic        enc_enable_q, enc_enable_d;
  logic [7:0]  enc_data_q, enc_data_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, busy_d;
  logic        err_sym_q, err_sym_d;

  logic        accept;
  logic        code_bad;
  logic [15:0] code_mask;
  logic [4:0]  shamt;
  logic [15:0] acc_app;
  logic [4:0]  cnt_app;
  logic        msg_end;

  assign accept   = (state_q == IDLE) && s_valid && s_ready_q;
  assign code_bad = (enc_len == '0) || (int'(enc_len) > MAX_LEN);

  // Valid bits live left-aligned in acc; a new code lands just below them.
  assign code_mask = 16'(enc_code) & ((16'd1 << enc_len) - 16'd1);
  assign shamt     = 5'd16 - cnt_q - 5'(enc_len);
  assign acc_app   = acc_q | (code_mask << shamt);
  assign cnt_app   = cnt_q + 5'(enc_len);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    enc_data_d = enc_data_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    err_sym_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          enc_data_d = s_data;
          last_d     = s_last;
          state_d    = REQ;
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        if (code_bad) begin
          err_sym_d = 1'b1;
          if (last_q && cnt_q != 5'd0) begin
            state_d   = FLUSH;
            m_valid_d = 1'b1;
            m_data_d  = acc_q[15:8];
            m_last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end else begin
          acc_d = acc_app;
          cnt_d = cnt_app;
          if (cnt_app >= 5'd8) begin
            state_d   = EMIT;
            m_valid_d = 1'b1;
            m_data_d  = acc_app[15:8];
            m_last_d  = last_q && (cnt_app == 5'd8);
          end else if (last_q) begin
            state_d   = FLUSH;
            m_valid_d = 1'b1;
            m_data_d  = acc_app[15:8];
            m_last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      EMIT: begin
        if (m_ready) begin
          acc_d = acc_q << 8;
          cnt_d = cnt_q - 5'd8;
          if (last_q && cnt_q != 5'd8) begin
            state_d  = FLUSH;
            m_data_d = acc_q[7:0];
            m_last_d = 1'b1;
          end else begin
            state_d   = IDLE;
            last_d    = 1'b0;
            m_valid_d = 1'b0;
            m_data_d  = 8'h00;
            m_last_d  = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (m_ready) begin
          state_d   = IDLE;
          acc_d     = 16'h0000;
          cnt_d     = 5'd0;
          last_d    = 1'b0;
          m_valid_d = 1'b0;
          m_data_d  = 8'h00;
          m_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    s_ready_d    = (state_d == IDLE);
    enc_enable_d = (state_d == REQ);
    busy_d       = (state_d != IDLE) || (cnt_d != 5'd0);
  end

  assign msg_end = last_q && (state_q != IDLE) && (state_d == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= 16'h0000;
      cnt_q        <= 5'd0;
      last_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      enc_enable_q <= 1'b0;
      enc_data_q   <= 8'h00;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_sym_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      s_ready_q    <= s_ready_d;
      enc_enable_q <= enc_enable_d;
      enc_data_q   <= enc_data_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      err_sym_q    <= err_sym_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign enc_enable = enc_enable_q;
  assign enc_data   = enc_data_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign err_sym    = err_sym_q;

`ifdef HUFF_BITCOUNT_EN
  logic        msg_open_q, msg_open_d;
  logic [15:0] bit_count_q, bit_count_d;
  logic [16:0] bc_sum;

  assign bc_sum = {1'b0, bit_count_q} + 17'(enc_len);

  // Count survives the final handshake; only the next message's first symbol clears it.
  always_comb begin
    msg_open_d  = msg_open_q;
    bit_count_d = bit_count_q;
    if (accept) begin
      msg_open_d = 1'b1;
      if (!msg_open_q) bit_count_d = 16'h0000;
    end else begin
      if (state_q == CAP && !code_bad)
        bit_count_d = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
      if (msg_end) msg_open_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_open_q  <= 1'b0;
      bit_count_q <= 16'h0000;
    end else begin
      msg_open_q  <= msg_open_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`else
  logic unused_msg_end;
  assign unused_msg_end = msg_end;
`endif

endmodule

// File: tb/tb_huffman_pack_ctrl.sv
// Directed self-checking bench for huffman_pack_ctrl with a stub code table.
module tb_huffman_pack_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, s_ready;
  logic [7:0] s_data;
  logic       enc_enable;
  logic [7:0] enc_data;
  logic [7:0] enc_code;
  logic [3:0] enc_len;
  logic       m_valid, m_last, m_ready;
  logic [7:0] m_data;
  logic       busy, err_sym;
`ifdef HUFF_BITCOUNT_EN
  logic [15:0] bit_count;
`endif

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];

  huffman_pack_ctrl #(.MAX_LEN(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .enc_enable(enc_enable), .enc_data(enc_data),
    .enc_code(enc_code), .enc_len(enc_len),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err_sym(err_sym)
`ifdef HUFF_BITCOUNT_EN
    , .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  // Stub encoder; upper code bits carry junk that must be masked off.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_code <= 8'h00;
      enc_len  <= 4'd0;
    end else if (enc_enable) begin
      case (enc_data)
        8'h61:   begin enc_code <= 8'hFE; enc_len <= 4'd2; end
        8'h62:   begin enc_code <= 8'hFB; enc_len <= 4'd3; end
        8'h63:   begin enc_code <= 8'hFC; enc_len <= 4'd4; end
        8'h78:   begin enc_code <= 8'hA5; enc_len <= 4'd8; end
        8'h7A:   begin enc_code <= 8'hFF; enc_len <= 4'd0; end
        8'h71:   begin enc_code <= 8'hFF; enc_len <= 4'd9; end
        default: begin enc_code <= 8'h00; enc_len <= 4'd0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
      end
      if (err_sym) err_cnt++;
    end
  end

  task automatic send_sym(input logic [7:0] sym, input logic last);
    int n = 0;
    while (!s_ready && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL send_timeout sym=%h s_ready=%b required=1", sym, s_ready);
    end
    s_valid = 1'b1; s_data = sym; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !s_ready) && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy || !s_ready) begin
      failures++;
      $display("FAIL idle_timeout busy=%b s_ready=%b required busy=0 s_ready=1", busy, s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (!m_valid) begin
      failures++;
      $display("FAIL mvalid_timeout m_valid=%b required=1", m_valid);
    end
  endtask

  task automatic clear_obs();
    q_data.delete(); q_last.delete(); err_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
    checks++; if (enc_enable !== 1'b0) begin failures++; $display("FAIL rst_enc_enable got=%b exp=0", enc_enable); end
    checks++; if (busy !== 1'b0 || err_sym !== 1'b0 || m_last !== 1'b0) begin
      failures++; $display("FAIL rst_misc busy=%b err=%b m_last=%b exp=0,0,0", busy, err_sym, m_last);
    end
`ifdef HUFF_BITCOUNT_EN
    checks++; if (bit_count !== 16'h0) begin failures++; $display("FAIL rst_bit_count got=%h exp=0", bit_count); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_abc();
    clear_obs(); m_ready = 1'b1;
    send_sym(8'h61, 1'b0); send_sym(8'h62, 1'b0); send_sym(8'h63, 1'b1);
    wait_idle();
    checks++; if (q_data.size() != 2) begin failures++; $display("FAIL abc_count got=%0d exp=2", q_data.size()); end
    else begin
      checks++; if (q_data[0] !== 8'h9E || q_last[0] !== 1'b0) begin
        failures++; $display("FAIL abc_byte0 got=%h/%b exp=9e/0", q_data[0], q_last[0]);
      end
      checks++; if (q_data[1] !== 8'h00 || q_last[1] !== 1'b1) begin
        failures++; $display("FAIL abc_byte1 got=%h/%b exp=00/1", q_data[1], q_last[1]);
      end
    end
    checks++; if (busy !== 1'b0 || err_cnt != 0) begin
      failures++; $display("FAIL abc_after busy=%b errs=%0d exp=0,0", busy, err_cnt);
    end
`ifdef HUFF_BITCOUNT_EN
    checks++; if (bit_count !== 16'd9) begin failures++; $display("FAIL abc_bit_count got=%0d exp=9", bit_count); end
`endif
  endtask

  task automatic test_full_byte();
    int vcycles = 0;
    clear_obs(); m_ready = 1'b1;
    send_sym(8'h78, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (m_valid) vcycles++;
      @(posedge clk); #1;
    end
    checks++; if (q_data.size() != 1) begin failures++; $display("FAIL full_count got=%0d exp=1", q_data.size()); end
    else begin
      checks++; if (q_data[0] !== 8'hA5 || q_last[0] !== 1'b1) begin
        failures++; $display("FAIL full_byte got=%h/%b exp=a5/1", q_data[0], q_last[0]);
      end
    end
    checks++; if (vcycles != 1) begin failures++; $display("FAIL full_no_flush valid_cycles=%0d exp=1", vcycles); end
  endtask

  task automatic test_err_mid();
    clear_obs(); m_ready = 1'b1;
    send_sym(8'h61, 1'b0); send_sym(8'h7A, 1'b0); send_sym(8'h62, 1'b0); send_sym(8'h63, 1'b1);
    wait_idle();
    checks++; if (err_cnt != 1) begin failures++; $display("FAIL errmid_pulse got=%0d exp=1", err_cnt); end
    checks++; if (q_data.size() != 2) begin failures++; $display("FAIL errmid_count got=%0d exp=2", q_data.size()); end
    else begin
      checks++; if (q_data[0] !== 8'h9E || q_data[1] !== 8'h00 || q_last[1] !== 1'b1) begin
        failures++; $display("FAIL errmid_bytes got=%h,%h/%b exp=9e,00/1", q_data[0], q_data[1], q_last[1]);
      end
    end
`ifdef HUFF_BITCOUNT_EN
    checks++; if (bit_count !== 16'd9) begin failures++; $display("FAIL errmid_bit_count got=%0d exp=9", bit_count); end
`endif
  endtask

  task automatic test_backpressure();
    clear_obs(); m_ready = 1'b0;
    send_sym(8'h78, 1'b0);
    wait_mvalid();
    s_valid = 1'b1; s_data = 8'h62; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_last !== 1'b0 || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d v=%b d=%h l=%b rdy=%b exp=1,a5,0,0", i, m_valid, m_data, m_last, s_ready);
      end
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    send_sym(8'h61, 1'b1);
    wait_idle();
    checks++; if (q_data.size() != 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", q_data.size()); end
    else begin
      checks++; if (q_data[0] !== 8'hA5 || q_last[0] !== 1'b0 || q_data[1] !== 8'h80 || q_last[1] !== 1'b1) begin
        failures++; $display("FAIL stall_bytes got=%h/%b,%h/%b exp=a5/0,80/1", q_data[0], q_last[0], q_data[1], q_last[1]);
      end
    end
  endtask

  task automatic test_err_last_empty();
    clear_obs(); m_ready = 1'b1;
    send_sym(8'h7A, 1'b1);
    wait_idle();
    checks++; if (err_cnt != 1 || q_data.size() != 0) begin
      failures++; $display("FAIL errlast_len0 errs=%0d bytes=%0d exp=1,0", err_cnt, q_data.size());
    end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL errlast_idle busy=%b s_ready=%b exp=0,1", busy, s_ready);
    end
    send_sym(8'h71, 1'b1);
    wait_idle();
    checks++; if (err_cnt != 2 || q_data.size() != 0) begin
      failures++; $display("FAIL errlast_toolong errs=%0d bytes=%0d exp=2,0", err_cnt, q_data.size());
    end
`ifdef HUFF_BITCOUNT_EN
    checks++; if (bit_count !== 16'd0) begin failures++; $display("FAIL errlast_bit_count got=%0d exp=0", bit_count); end
`endif
  endtask

  task automatic test_reset_mid();
    clear_obs(); m_ready = 1'b0;
    send_sym(8'h61, 1'b0);
    send_sym(8'h78, 1'b0);
    wait_mvalid();
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || enc_enable !== 1'b0 || s_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_outs v=%b d=%h en=%b rdy=%b exp=0,00,0,0", m_valid, m_data, enc_enable, s_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    send_sym(8'h61, 1'b0); send_sym(8'h62, 1'b1);
    wait_idle();
    checks++; if (q_data.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", q_data.size()); end
    else begin
      checks++; if (q_data[0] !== 8'h98 || q_last[0] !== 1'b1) begin
        failures++; $display("FAIL midrst_byte got=%h/%b exp=98/1", q_data[0], q_last[0]);
      end
    end
`ifdef HUFF_BITCOUNT_EN
    checks++; if (bit_count !== 16'd5) begin failures++; $display("FAIL midrst_bit_count got=%0d exp=5", bit_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_byte();
    test_err_mid();
    test_backpressure();
    test_err_last_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/huffman_pack_ctrl.md
Name: huffman_pack_ctrl

Overview:
- Sequencer and bit packer around the static-table Huffman encoder.
- Accepts ASCII symbols on a valid/ready stream and drives the encoder's enable/data_in one symbol at a time.
- Captures the returned right-aligned code word plus its length from the companion length table, and packs the variable-length codes MSB-first into bytes.
- Emits the packed bytes on a valid/ready stream with end-of-message padding.

Parameters:
- MAX_LEN, 8, maximum legal code length in bits; codes longer than this are rejected.
- LEN_W, 4, width of the code-length input.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input symbol valid.
- s_data  in  8  input ASCII symbol.
- s_last  in  1  symbol is the last of the message.
- s_ready  out  1  block accepts a symbol.
- enc_enable  out  1  enable to the encoder, one-cycle pulse per symbol.
- enc_data  out  8  symbol to the encoder data_in, registered.
- enc_code  in  8  encoder data_out; code right-aligned.
- enc_len  in  LEN_W  code length for the current enc_data; 0 means unmapped.
- m_valid  out  1  packed byte valid.
- m_data  out  8  packed byte; first code bit in bit 7.
- m_last  out  1  final byte of the message.
- m_ready  in  1  downstream accepts the byte.
- busy  out  1  high whenever state != IDLE or the bit count != 0.
- err_sym  out  1  one-cycle pulse when a symbol is dropped.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, accumulator 0, bit count 0, last flag 0. Reset mid-message discards all held bits; no partial byte is emitted.
- State IDLE:
  - s_ready=1.
  - On s_valid&s_ready: latch s_data into enc_data and s_last into last_q; go to REQ.
- State REQ:
  - enc_enable=1 for exactly this cycle; enc_data held stable.
  - The encoder registers the code at the end of REQ. Go to CAP.
- State CAP: sample enc_code and enc_len.
  - If enc_len==0 or enc_len>MAX_LEN: pulse err_sym and append no bits.
  - Otherwise append bits enc_code[enc_len-1:0], MSB first, below the existing bits in a 16-bit accumulator; cnt += enc_len.
  - Next state:
    - cnt>=8 → EMIT.
    - last_q and 0<cnt<8 → FLUSH.
    - last_q and cnt==0 → IDLE; nothing is emitted, and last_q is cleared.
    - Otherwise → IDLE.
- State EMIT:
  - m_valid=1, m_data = top 8 valid bits.
  - m_last = last_q and (cnt==8).
  - Hold m_data/m_last stable until m_ready.
  - On handshake: shift the accumulator left 8, cnt -= 8.
  - Next state: last_q and cnt>0 → FLUSH; else → IDLE, with last_q cleared if set.
  - Since cnt<8 before append and enc_len<=8, cnt<=15, so at most one EMIT per symbol.
- State FLUSH:
  - m_valid=1, m_last=1, m_data = remaining cnt bits left-aligned with zero padding in the low bits.
  - On m_ready: cnt=0, last_q=0 → IDLE.
- Bits carry across symbols within a message. A new message always starts byte-aligned.
- Throughput: best case 3 cycles/symbol (IDLE→REQ→CAP); 4 cycles when a byte is emitted with m_ready=1.
- Latency: s_valid accept to first possible m_valid is 3 cycles.
- s_ready is low in every state except IDLE, so backpressure on m_ready stalls the input.

Optional Feature:
- Macro: HUFF_BITCOUNT_EN.
- When defined:
  - Extra output port bit_count (16 bits): total code bits appended in the current message, padding excluded.
  - Saturates at 16'hFFFF.
  - Holds its value after the m_last handshake; cleared to 0 when the next message's first symbol is accepted.
  - Reset value 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Stub table a=2'b10/len2, b=3'b011/len3, c=4'b1100/len4; send "abc" with s_last on c, m_ready=1 → m_data 8'h9E (m_last=0), then 8'h00 (m_last=1); busy=0 afterwards; bit_count=9 if enabled.
- Single symbol with enc_code=8'hA5, enc_len=8, s_last=1 → exactly one byte 8'hA5 with m_last=1; no FLUSH cycle.
- Symbol with enc_len=0 mid-message → err_sym high for 1 cycle, no bits added; the next valid symbol packs as if the dropped one never arrived.
- Hold m_ready=0 for 5 cycles during EMIT → m_valid stays 1, m_data/m_last unchanged, s_ready=0, no input accepted.
- Last symbol enc_len=0 with cnt==0 → no output byte, err_sym pulse, return to IDLE, busy=0.
- Assert rst_n=0 during EMIT → m_valid, m_data, enc_enable, s_ready all 0 immediately; after release, a new 2-symbol message packs from byte alignment.
